mem_port_arbiter: RTL and testbench

//  Shares the single 8-bit x 13-bit-address program/data memory between two requesters:

---
 rtl/cpu_mem_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/rr_arbiter_2.sv | 13 +
 rtl/mem_port_arbiter.sv | 86 ++++++++
 tb/tb_mem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
// Holds the memory geometry, the arbiter state encoding and the grant helper.
package cpu_mem_pkg;

    localparam int ADDR_WIDTH = 13;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef logic [ADDR_WIDTH-1:0] mem_addr_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for the memory-port arbiter.
// master = requesters plus memory model, slave = the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = cpu_mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cpu_mem_pkg::DATA_WIDTH
) ();

    logic [1:0]            req;
    logic [1:0]            we;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic [1:0]            gnt;
    logic [1:0]            done;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt, done, rdata, mem_address, mem_write_data,
        input  mem_read, mem_write
    );

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt, done, rdata, mem_address, mem_write_data,
        output mem_read, mem_write
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin pick.
// A lone requester wins outright; under contention the port not served last wins.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner,
    output logic       any
);

    assign any    = |req;
    assign winner = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the shared program/data memory.
// Each access: one IDLE pick, MEM_LATENCY strobe cycles, one done cycle.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = cpu_mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = cpu_mem_pkg::DATA_WIDTH,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    import cpu_mem_pkg::*;

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    arb_state_t    state;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          we_l;
    logic          winner;
    logic          any;

    rr_arbiter_2 u_rr (
        .req        (bus.req),
        .last_grant (last_grant),
        .winner     (winner),
        .any        (any)
    );

    // last_grant doubles as the owner of the in-flight access
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            last_grant         <= 1'b1;
            we_l               <= 1'b0;
            bus.gnt            <= 2'b00;
            bus.done           <= 2'b00;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.rdata          <= '0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        last_grant         <= winner;
                        we_l               <= bus.we[winner];
                        bus.mem_address    <= winner ? bus.addr1 : bus.addr0;
                        bus.mem_write_data <= winner ? bus.wdata1 : bus.wdata0;
                        cnt                <= CNT_INIT;
                        bus.gnt            <= port_onehot(winner);
                        bus.mem_read       <= ~bus.we[winner];
                        bus.mem_write      <= bus.we[winner];
                        state              <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!we_l) begin
                            bus.rdata <= bus.mem_rdata;
                        end
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        bus.done      <= port_onehot(last_grant);
                        state         <= RESP;
                    end
                end
                RESP: begin
                    bus.gnt  <= 2'b00;
                    bus.done <= 2'b00;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// a randomized run against a transaction-level timing model.
module tb_mem_port_arbiter;

    import cpu_mem_pkg::*;

    localparam int L = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus  ();
    mem_port_arbiter_if bus1 ();

    mem_port_arbiter #(.MEM_LATENCY(L)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.req = 2'b00;  bus.we = 2'b00;
        bus.addr0 = '0;   bus.addr1 = '0;
        bus.wdata0 = '0;  bus.wdata1 = '0;
        bus.mem_rdata = '0;
        bus1.req = 2'b00; bus1.we = 2'b00;
        bus1.addr0 = '0;  bus1.addr1 = '0;
        bus1.wdata0 = '0; bus1.wdata1 = '0;
        bus1.mem_rdata = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        do_reset();
        checks++;
        if ({bus.gnt, bus.done, bus.mem_read, bus.mem_write} !== 6'b0)
            $display("FAIL reset_ctl got=%b exp=0",
                     {bus.gnt, bus.done, bus.mem_read, bus.mem_write});
        checks++;
        if ({bus.rdata, bus.mem_address, bus.mem_write_data} !== '0)
            $display("FAIL reset_data got=%h/%h/%h exp=0",
                     bus.rdata, bus.mem_address, bus.mem_write_data);
        if ({bus.rdata, bus.mem_address, bus.mem_write_data} !== '0) errors++;
        if ({bus.gnt, bus.done, bus.mem_read, bus.mem_write} !== 6'b0) errors++;
        checks++;
        if ({bus1.gnt, bus1.done, bus1.mem_read, bus1.mem_write} !== 6'b0) begin
            errors++;
            $display("FAIL reset_lat1 got=%b exp=0",
                     {bus1.gnt, bus1.done, bus1.mem_read, bus1.mem_write});
        end
    endtask

    task automatic test_single_read;
        tick();
        bus.req = 2'b01; bus.we = 2'b00;
        bus.addr0 = 13'h0010; bus.mem_rdata = 8'hA5;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 ||
                bus.mem_address !== 13'h0010 || bus.gnt !== 2'b01 ||
                bus.done !== 2'b00) begin
                errors++;
                $display("FAIL read_strobe T+%0d rd=%b wr=%b a=%h g=%b d=%b exp 1 0 0010 01 00",
                         k, bus.mem_read, bus.mem_write, bus.mem_address,
                         bus.gnt, bus.done);
            end
        end
        tick();
        checks++;
        if (bus.done !== 2'b01 || bus.rdata !== 8'hA5 || bus.mem_read !== 1'b0) begin
            errors++;
            $display("FAIL read_done d=%b rdata=%h rd=%b exp 01 a5 0",
                     bus.done, bus.rdata, bus.mem_read);
        end
        bus.req = 2'b00;
        tick();
        checks++;
        if (bus.done !== 2'b00 || bus.gnt !== 2'b00) begin
            errors++;
            $display("FAIL read_after d=%b g=%b exp 00 00", bus.done, bus.gnt);
        end
    endtask

    task automatic test_single_write;
        bus.req = 2'b10; bus.we = 2'b10;
        bus.addr1 = 13'h1FFF; bus.wdata1 = 8'h3C;
        bus.mem_rdata = 8'h77;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 ||
                bus.mem_write_data !== 8'h3C || bus.mem_address !== 13'h1FFF ||
                bus.gnt !== 2'b10) begin
                errors++;
                $display("FAIL write_strobe T+%0d wr=%b rd=%b wd=%h a=%h g=%b exp 1 0 3c 1fff 10",
                         k, bus.mem_write, bus.mem_read, bus.mem_write_data,
                         bus.mem_address, bus.gnt);
            end
        end
        tick();
        checks++;
        if (bus.done !== 2'b10 || bus.rdata !== 8'hA5) begin
            errors++;
            $display("FAIL write_done d=%b rdata=%h exp 10 a5", bus.done, bus.rdata);
        end
        bus.req = 2'b00; bus.we = 2'b00;
        tick();
    endtask

    task automatic test_contention;
        int dcyc[$];
        int dport[$];
        idle_inputs();
        bus.req = 2'b11;
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            tick();
            checks++;
            if ((bus.mem_read && bus.mem_write) || bus.gnt === 2'b11) begin
                errors++;
                $display("FAIL contend_excl c=%0d g=%b rd=%b wr=%b",
                         c, bus.gnt, bus.mem_read, bus.mem_write);
            end
            if (bus.done !== 2'b00) begin
                dcyc.push_back(c);
                dport.push_back(bus.done == 2'b01 ? 0 : (bus.done == 2'b10 ? 1 : 99));
            end
        end
        checks++;
        if (dcyc.size() != 4) begin
            errors++;
            $display("FAIL contend_count got=%0d exp=4", dcyc.size());
        end
        for (int i = 0; i < 4 && i < dcyc.size(); i++) begin
            checks++;
            if (dport[i] != i % 2 || dcyc[i] != 3 + 4 * i) begin
                errors++;
                $display("FAIL contend_done%0d port=%0d cyc=%0d exp port=%0d cyc=%0d",
                         i, dport[i], dcyc[i], i % 2, 3 + 4 * i);
            end
        end
        bus.req = 2'b00;
        repeat (4) tick();
    endtask

    task automatic test_req_drop;
        bus.req = 2'b01; bus.we = 2'b00;
        bus.addr0 = 13'h0123; bus.mem_rdata = 8'h5A;
        tick();
        bus.req = 2'b00; bus.addr0 = 13'h0555;
        for (int k = 1; k <= 2; k++) begin
            checks++;
            if (bus.mem_address !== 13'h0123 || bus.mem_read !== 1'b1) begin
                errors++;
                $display("FAIL drop_addr T+%0d a=%h rd=%b exp 0123 1",
                         k, bus.mem_address, bus.mem_read);
            end
            tick();
        end
        checks++;
        if (bus.done !== 2'b01 || bus.rdata !== 8'h5A) begin
            errors++;
            $display("FAIL drop_done d=%b rdata=%h exp 01 5a", bus.done, bus.rdata);
        end
        tick();
        checks++;
        if (bus.done !== 2'b00 || bus.gnt !== 2'b00) begin
            errors++;
            $display("FAIL drop_after d=%b g=%b exp 00 00", bus.done, bus.gnt);
        end
    endtask

    task automatic test_reset_mid_access;
        bus.req = 2'b01; bus.we = 2'b00;
        bus.addr0 = 13'h0040; bus.mem_rdata = 8'hEE;
        tick();
        checks++;
        if (bus.mem_read !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_start rd=%b exp 1", bus.mem_read);
        end
        rst = 1'b1; bus.req = 2'b00;
        tick();
        checks++;
        if ({bus.gnt, bus.done, bus.mem_read, bus.mem_write} !== 6'b0 ||
            {bus.rdata, bus.mem_address, bus.mem_write_data} !== '0) begin
            errors++;
            $display("FAIL rstmid_zero g=%b d=%b rd=%b wr=%b rdata=%h a=%h wd=%h exp all 0",
                     bus.gnt, bus.done, bus.mem_read, bus.mem_write,
                     bus.rdata, bus.mem_address, bus.mem_write_data);
        end
        rst = 1'b0; bus.req = 2'b11;
        tick();
        checks++;
        if (bus.done !== 2'b00 || bus.gnt !== 2'b01 || bus.mem_read !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_regrant d=%b g=%b rd=%b exp 00 01 1",
                     bus.done, bus.gnt, bus.mem_read);
        end
        bus.req = 2'b00;
        repeat (4) tick();
    endtask

    task automatic test_latency1;
        logic [1:0] exp_d;
        bus1.req = 2'b01; bus1.we = 2'b00; bus1.addr0 = 13'h0007;
        for (int k = 0; k < 9; k++) begin
            bus1.mem_rdata = 8'(16 + k);
            tick();
            exp_d = ((k + 1) % 3 == 2) ? 2'b01 : 2'b00;
            checks++;
            if (bus1.mem_read !== ((k + 1) % 3 == 1) || bus1.mem_write !== 1'b0 ||
                bus1.done !== exp_d) begin
                errors++;
                $display("FAIL lat1 c=%0d rd=%b wr=%b d=%b exp rd=%b d=%b",
                         k + 1, bus1.mem_read, bus1.mem_write, bus1.done,
                         ((k + 1) % 3 == 1), exp_d);
            end
            if (exp_d == 2'b01) begin
                checks++;
                if (bus1.rdata !== 8'(16 + k)) begin
                    errors++;
                    $display("FAIL lat1_rdata c=%0d got=%h exp=%h",
                             k + 1, bus1.rdata, 8'(16 + k));
                end
            end
        end
        bus1.req = 2'b00;
        repeat (3) tick();
    endtask

    task automatic test_random;
        int        g;
        int        next_free;
        logic      last;
        logic      p;
        logic      lat_port;
        logic      lat_we;
        mem_addr_t lat_addr;
        logic [7:0] lat_wd;
        logic [7:0] md_save;
        logic [7:0] exp_rdata;
        logic [1:0] exp_g;
        logic [1:0] exp_d;
        bit        in_acc;
        bit        in_done;
        idle_inputs();
        do_reset();
        g = -100; next_free = 0; last = 1'b1;
        lat_port = 1'b0; lat_we = 1'b0; lat_addr = '0; lat_wd = '0;
        md_save = '0; exp_rdata = '0;
        for (int c = 0; c < 300; c++) begin
            in_acc  = (c >= g + 1) && (c <= g + L);
            in_done = (c == g + L + 1);
            exp_g = (in_acc || in_done) ? (lat_port ? 2'b10 : 2'b01) : 2'b00;
            exp_d = in_done ? (lat_port ? 2'b10 : 2'b01) : 2'b00;
            if (in_done && !lat_we) exp_rdata = md_save;
            checks++;
            if (bus.gnt !== exp_g || bus.done !== exp_d ||
                bus.mem_read !== (in_acc && !lat_we) ||
                bus.mem_write !== (in_acc && lat_we) || bus.rdata !== exp_rdata) begin
                errors++;
                $display("FAIL rand_ctl c=%0d g=%b d=%b rd=%b wr=%b rdata=%h exp %b %b %b %b %h",
                         c, bus.gnt, bus.done, bus.mem_read, bus.mem_write, bus.rdata,
                         exp_g, exp_d, in_acc && !lat_we, in_acc && lat_we, exp_rdata);
            end
            if (in_acc) begin
                checks++;
                if (bus.mem_address !== lat_addr ||
                    (lat_we && bus.mem_write_data !== lat_wd)) begin
                    errors++;
                    $display("FAIL rand_bus c=%0d a=%h wd=%h exp a=%h wd=%h",
                             c, bus.mem_address, bus.mem_write_data, lat_addr, lat_wd);
                end
            end
            bus.req = 2'($urandom_range(0, 3));
            bus.we = 2'($urandom_range(0, 3));
            bus.addr0 = 13'($urandom); bus.addr1 = 13'($urandom);
            bus.wdata0 = 8'($urandom); bus.wdata1 = 8'($urandom);
            bus.mem_rdata = 8'($urandom);
            if (c == g + L) md_save = bus.mem_rdata;
            if (c >= next_free && bus.req != 2'b00) begin
                p = (bus.req == 2'b11) ? ~last : bus.req[1];
                lat_port = p;
                lat_we = bus.we[p];
                lat_addr = p ? bus.addr1 : bus.addr0;
                lat_wd = p ? bus.wdata1 : bus.wdata0;
                last = p;
                g = c;
                next_free = c + L + 2;
            end
            tick();
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_req_drop();
        test_reset_mid_access();
        test_latency1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
